// File: rtl/vga_scanner.sv
// VGA raster scanner: divides the system clock by two into a pixel rate and
// walks (row, col) over the full timing frame, decoding syncs and blanking.
module vga_scanner #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       HS_n,
  output logic       VS_n,
  output logic       blank,
  output logic       pixel_en,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All coordinate compares are done at 10 bits unsigned.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       tick_q, tick_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       col_wrap_s;
  logic       row_wrap_s;

  assign col_wrap_s = (col_q == H_LAST);
  assign row_wrap_s = (row_q == V_LAST);

  // Next-state: coordinates only move on edges where the divider is high.
  always_comb begin
    tick_d = ~tick_q;
    col_d  = col_q;
    row_d  = row_q;
    if (tick_q) begin
      if (col_wrap_s) begin
        col_d = 10'd0;
        if (row_wrap_s) begin
          row_d = 10'd0;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Divider and scan position registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q <= 1'b0;
      col_q  <= 10'd0;
      row_q  <= 10'd0;
    end else begin
      tick_q <= tick_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign row       = row_q;
  assign col       = col_q;
  assign pixel_en  = tick_q;

  // Decodes are combinational on the live coordinates so they never lag them.
  assign HS_n      = ~((col_q >= HS_FIRST) && (col_q <= HS_LAST));
  assign VS_n      = ~((row_q >= VS_FIRST) && (row_q <= VS_LAST));
  assign blank     = (col_q >= H_VIS_END) || (row_q >= V_VIS_END);
  assign frame_end = tick_q && col_wrap_s && row_wrap_s;

endmodule

// File: doc/vga_scanner.md
VGA_SCANNER -- requirements
Module: vga_scanner

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 clock  input  1  system clock, 50 MHz nominal; single clock domain.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 row  output  10  current line index, 0 .. V_TOTAL-1.
REQ-012 col  output  10  current pixel index within line, 0 .. H_TOTAL-1.
REQ-013 HS_n  output  1  horizontal sync, active low.
REQ-014 VS_n  output  1  vertical sync, active low.
REQ-015 blank  output  1  high when (row, col) is outside the visible area.
REQ-016 pixel_en  output  1  high on clocks whose rising edge advances col.
REQ-017 frame_end  output  1  one-clock pulse on the final pixel-advance of each frame.

Function
REQ-018 H_TOTAL SHALL be H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL be V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 Internal divider flop tick SHALL toggle on every rising clock edge, giving a 25 MHz pixel rate; pixel_en SHALL equal tick.
REQ-020 At a rising edge with tick==1, col SHALL increment by 1; at any edge with tick==0, col and row SHALL hold.
REQ-021 Wrap: at an advancing edge with col==H_TOTAL-1, col SHALL become 0 and row SHALL increment by 1.
REQ-022 Wrap: at an advancing edge with col==H_TOTAL-1 and row==V_TOTAL-1, col and row SHALL both become 0 on the same edge.
REQ-023 row and col SHALL be driven directly from flops; no out-of-range value (col>=H_TOTAL, row>=V_TOTAL) SHALL ever appear.
REQ-024 HS_n SHALL be 0 iff H_VISIBLE+H_FRONT <= col <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751), else 1.
REQ-025 VS_n SHALL be 0 iff V_VISIBLE+V_FRONT <= row <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491), else 1.
REQ-026 blank SHALL be 1 iff col>=H_VISIBLE or row>=V_VISIBLE.
REQ-027 HS_n, VS_n and blank SHALL be combinational decodes of the current row/col, so they align in the same cycle as the coordinates they describe, with zero latency.
REQ-028 frame_end SHALL be 1 iff tick==1 and col==H_TOTAL-1 and row==V_TOTAL-1; this makes it exactly one clock wide, once per frame (every 2*800*525 = 840000 clocks).
REQ-029 Width rule: all compares SHALL be performed at 10 bits unsigned; the default totals SHALL fit (799, 524 < 1024).

Reset
REQ-030 While reset==1, tick, row and col SHALL be 0 immediately, independent of clock.
REQ-031 Output values during reset SHALL be: row=0, col=0, pixel_en=0, HS_n=1, VS_n=1, blank=0, frame_end=0.
REQ-032 After reset deasserts, the first edge SHALL set tick to 1 without advancing; the second edge SHALL set col to 1.
REQ-033 When reset is asserted mid-frame, the frame SHALL be abandoned with no frame_end pulse; the scan SHALL restart at (0,0).

Verification
REQ-034 Reset release, run 6 clocks -> col sequence 0,0,1,1,2,2 and row=0; pixel_en alternates 0,1,0,1,...
REQ-035 Run to col=655 then col=656 -> HS_n goes 1->0 at 656; HS_n returns to 1 at col=752; measured low width is 192 clocks.
REQ-036 Run to row=524, col=799 with tick=1 -> frame_end=1 for exactly one clock; next edge gives row=0, col=0.
REQ-037 Full-frame run -> VS_n low for exactly rows 490-491 (3200 clocks); frame_end period is 840000 clocks; blank=0 count per frame is 307200 pixels.
REQ-038 Assert reset asynchronously (between edges) at row=300, col=400 -> row/col are 0 before the next edge; no frame_end pulse; after release the restart matches REQ-034.
REQ-039 Boundary check: at col=639, blank=0; at col=640, blank=1 (row<480); at row=480, blank=1 for every col.
